charge_drain: RTL
=================

CHARGE_DRAIN -- requirements
Module: charge_drain

Interface
REQ-001 Parameter NUM_POINTS, default 4096, total gridpoints drained per pass; must be a multiple of 8 and not exceed 4096.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse from the scatterer's done output; begins one drain pass.
REQ-005 valid_req  output  1  request strobe to the scatterer pair.
REQ-006 grid_addr_out  output  addr_t [3:0] x 2 lanes  gridpoint addresses for the request.
REQ-007 charge_rdy  input  1  scatterer response strobe.
REQ-008 charge_in  input  charge_t [3:0] x 2 lanes  summed charges returned for grid_addr_out.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream stream handshake.
REQ-010 out_addr  output  addr_t  gridpoint address of the current beat.
REQ-011 out_charge  output  charge_t  charge of the current beat.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 finished  output  1  single-cycle pulse when a pass completes.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, DRAIN, FIN; IDLE->REQ on start; REQ->WAIT after one cycle; WAIT->DRAIN on charge_rdy; DRAIN->REQ after 8th accepted beat when base+8 < NUM_POINTS, else DRAIN->FIN; FIN->IDLE after one cycle.
REQ-015 start is ignored outside IDLE; a pass cannot be restarted mid-drain.
REQ-016 valid_req is high for exactly the one cycle in REQ.
REQ-017 grid_addr_out[l][j] = base + 4*l + j; held stable from REQ through WAIT.
REQ-018 base is a counter of width clog2(NUM_POINTS)+1; it clears to 0 on start and advances by 8 on the DRAIN exit.
REQ-019 In WAIT, on charge_rdy, all 8 charge_in words are captured into an 8-entry buffer in the same cycle; charge_rdy outside WAIT is ignored.
REQ-020 DRAIN emits beats in order lane0 j0..j3, then lane1 j0..j3; out_addr equals the corresponding grid_addr_out value.
REQ-021 A beat transfers when out_valid and out_ready are both high; out_addr and out_charge hold while out_valid is high and out_ready is low.
REQ-022 out_valid is high throughout DRAIN until the 8th transfer, and low in all other states.
REQ-023 Sustained throughput with out_ready held high is one beat per cycle within DRAIN; per-request overhead is 2 cycles plus scatterer latency.
REQ-024 finished asserts in FIN only.

Reset
REQ-025 On rst low (asynchronous): state=IDLE, base=0, buffer=0; valid_req, out_valid, busy and finished are 0; grid_addr_out, out_addr and out_charge are 0.
REQ-026 Reset asserted mid-pass abandons the pass; no finished pulse is produced and no further beats are emitted after release.

Configuration
REQ-027 Macro CHARGE_DRAIN_SUM_EN: when defined, adds output total_charge (signed, width CWIDTH+12) and output sum_valid.
REQ-028 With the macro, total_charge clears on start and adds out_charge (sign-extended) on every transfer; sum_valid pulses together with finished, and total_charge holds until the next start.
REQ-029 Without the macro, total_charge, sum_valid and the accumulator are absent; all other behaviour is identical.

Structure
REQ-030 The shared package supplies addr_t (12 bit), charge_t (signed, CWIDTH bits) and CWIDTH; the drain state enum also belongs in the package.
REQ-031 One sub-module, charge_serializer: the 8-entry buffer plus the beat index and handshake; the FSM and address generation stay in the top module.

Verification
REQ-032 NUM_POINTS=16; start pulse; model returns charge=addr after 3 cycles; out_ready=1 -> 16 beats with addr 0..15 and charge 0..15, exactly 2 valid_req pulses, one finished pulse.
REQ-033 out_ready toggled 1/0 every cycle -> identical beat sequence with no drops or duplicates; out_addr/out_charge stable while stalled.
REQ-034 start pulsed again during DRAIN of the first request -> ignored; a single pass of 16 beats.
REQ-035 Spurious charge_rdy in IDLE and in DRAIN -> no capture and no state change; delayed charge_rdy (20 cycles) -> valid_req not reissued, grid_addr_out held.
REQ-036 rst low during WAIT of the 2nd request -> all outputs 0 immediately; no finished pulse; a new start gives a full pass from addr 0.
REQ-037 With CHARGE_DRAIN_SUM_EN, charges -5 at every point, NUM_POINTS=16 -> total_charge = -80 with sum_valid coincident with finished.

Source files
------------

// File: rtl/charge_drain_pkg.sv
// Shared types for the charge drain slice: address/charge words, request grids
// and the drain FSM state encoding.
package charge_drain_pkg;

   localparam int unsigned CWIDTH = 16;
   localparam int unsigned AWIDTH = 12;
   localparam int unsigned SWIDTH = CWIDTH + 12;
   localparam int unsigned LANES  = 2;
   localparam int unsigned WORDS  = 4;
   localparam int unsigned BEATS  = LANES * WORDS;

   typedef logic [AWIDTH-1:0]        addr_t;
   typedef logic signed [CWIDTH-1:0] charge_t;

   typedef addr_t   [LANES-1:0][WORDS-1:0] addr_grid_t;
   typedef charge_t [LANES-1:0][WORDS-1:0] charge_grid_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN,
      FIN
   } drain_state_t;

endpackage

// File: rtl/charge_drain_serializer.sv
// Eight-entry charge buffer that streams one captured request out as
// lane0 j0..j3 then lane1 j0..j3 over a valid/ready handshake.
module charge_serializer
   import charge_drain_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  charge_grid_t charge_in,
   input  addr_t        base_addr,
   input  logic         out_ready,
   output logic         out_valid,
   output addr_t        out_addr,
   output charge_t      out_charge,
   output logic         last_xfer
);

   // Flattened grid: element k = 4*lane + word, matching beat order.
   charge_t [BEATS-1:0] data_q;
   logic    [2:0]       idx_q;

   assign last_xfer  = out_valid && out_ready && (idx_q == 3'd7);
   assign out_addr   = base_addr + addr_t'(idx_q);
   assign out_charge = data_q[idx_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q    <= '0;
         idx_q     <= '0;
         out_valid <= 1'b0;
      end else if (capture) begin
         data_q    <= charge_in;
         idx_q     <= '0;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         idx_q <= idx_q + 3'd1;
         if (idx_q == 3'd7)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/charge_drain.sv
// Drains NUM_POINTS gridpoint charges from the scatterer pair, 8 per request.
// Optional running total and sum_valid output under CHARGE_DRAIN_SUM_EN.
module charge_drain
   import charge_drain_pkg::*;
#(
   parameter int unsigned NUM_POINTS = 4096
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         valid_req,
   output addr_grid_t   grid_addr_out,
   input  logic         charge_rdy,
   input  charge_grid_t charge_in,
   output logic         out_valid,
   input  logic         out_ready,
   output addr_t        out_addr,
   output charge_t      out_charge,
   output logic         busy,
`ifdef CHARGE_DRAIN_SUM_EN
   output logic signed [SWIDTH-1:0] total_charge,
   output logic         sum_valid,
`endif
   output logic         finished
);

   localparam int unsigned     BW    = $clog2(NUM_POINTS) + 1;
   localparam logic [BW-1:0]   LIMIT = BW'(NUM_POINTS);

   drain_state_t  state;
   logic [BW-1:0] base;
   logic [BW-1:0] next_base;
   logic          capture;
   logic          last_xfer;
   logic          pass_done;

   assign next_base = base + BW'(BEATS);
   assign capture   = (state == WAIT) && charge_rdy;
   assign pass_done = (state == DRAIN) && last_xfer && !(next_base < LIMIT);

   function automatic addr_grid_t lane_addrs(input logic [BW-1:0] b);
      addr_grid_t g;
      for (int unsigned l = 0; l < LANES; l++)
         for (int unsigned j = 0; j < WORDS; j++)
            g[l][j] = addr_t'(b) + addr_t'(WORDS * l + j);
      return g;
   endfunction

   // Request addresses are registered so they read zero out of reset and
   // stay frozen from REQ until the next request is launched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         base          <= '0;
         valid_req     <= 1'b0;
         busy          <= 1'b0;
         finished      <= 1'b0;
         grid_addr_out <= '0;
      end else begin
         valid_req <= 1'b0;
         finished  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state         <= REQ;
               base          <= '0;
               grid_addr_out <= lane_addrs('0);
               valid_req     <= 1'b1;
               busy          <= 1'b1;
            end
            REQ:  state <= WAIT;
            WAIT: if (charge_rdy) state <= DRAIN;
            DRAIN: if (last_xfer) begin
               base <= next_base;
               if (pass_done) begin
                  state    <= FIN;
                  finished <= 1'b1;
               end else begin
                  state         <= REQ;
                  valid_req     <= 1'b1;
                  grid_addr_out <= lane_addrs(next_base);
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   charge_serializer u_serializer (
      .clk        (clk),
      .rst        (rst),
      .capture    (capture),
      .charge_in  (charge_in),
      .base_addr  (grid_addr_out[0][0]),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_addr   (out_addr),
      .out_charge (out_charge),
      .last_xfer  (last_xfer)
   );

`ifdef CHARGE_DRAIN_SUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_charge <= '0;
         sum_valid    <= 1'b0;
      end else begin
         sum_valid <= pass_done;
         if ((state == IDLE) && start)
            total_charge <= '0;
         else if (out_valid && out_ready)
            total_charge <= total_charge + SWIDTH'(out_charge);
      end
   end
`endif

endmodule
